// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serialising memory controller: access sizes,
// FSM states, transaction owner and the size-to-byte-count helper.
package mem_ctrl_pkg;

  // Access size encodings as driven by the MEM stage (ram_state).
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  // Number of bytes moved for a given size code; 2'b10 is reserved and
  // handled as a full word.
  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SIZE_B:  n = 3'd1;
      SIZE_H:  n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates IF fetches and MEM loads/stores onto a single
// byte-wide RAM port, serialises each transaction into byte accesses and
// returns little-endian assembled data with a one-cycle done pulse.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_done_o,
  output logic [31:0] if_data_o,
  input  logic        mem_r_req_i,
  input  logic        mem_w_req_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_w_data_i,
  input  logic [1:0]  mem_state_i,
  output logic        mem_done_o,
  output logic [31:0] mem_r_data_o,
  input  logic [7:0]  ram_din_i,
  output logic [7:0]  ram_dout_o,
  output logic [31:0] ram_a_o,
  output logic        ram_wr_o
);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [31:0] base_q, base_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;

  // State and transaction registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IF;
      base_q  <= '0;
      n_q     <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
      n_q     <= n_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Arbitration, byte sequencing, data assembly and output decode.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    base_d       = base_q;
    n_d          = n_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    ram_a_o      = '0;
    ram_dout_o   = '0;
    ram_wr_o     = 1'b0;
    if_done_o    = 1'b0;
    if_data_o    = '0;
    mem_done_o   = 1'b0;
    mem_r_data_o = '0;

    case (state_q)
      ST_IDLE: begin
        // Store wins over load (also when both are illegally high), then fetch.
        if (mem_w_req_i) begin
          state_d = ST_WR;
          owner_d = OWN_MEM;
          base_d  = mem_addr_i;
          n_d     = size_to_n(mem_state_i);
          wdata_d = mem_w_data_i;
          cnt_d   = '0;
          data_d  = '0;
        end else if (mem_r_req_i) begin
          state_d = ST_RD;
          owner_d = OWN_MEM;
          base_d  = mem_addr_i;
          n_d     = size_to_n(mem_state_i);
          cnt_d   = '0;
          data_d  = '0;
        end else if (if_req_i) begin
          state_d = ST_RD;
          owner_d = OWN_IF;
          base_d  = if_addr_i;
          n_d     = 3'd4;
          cnt_d   = '0;
          data_d  = '0;
        end
      end

      ST_RD: begin
        if (cnt_q < n_q) begin
          ram_a_o = base_q + {29'd0, cnt_q};
        end
        // RAM returns the byte addressed one cycle earlier, so byte cnt-1
        // lands now; the 2-bit wrap maps cnt=4 onto byte lane 3.
        if (cnt_q != 3'd0) begin
          data_d[{(cnt_q[1:0] - 2'd1), 3'b000} +: 8] = ram_din_i;
        end
        if (cnt_q == n_q) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      ST_WR: begin
        ram_a_o    = base_q + {29'd0, cnt_q};
        ram_dout_o = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        ram_wr_o   = 1'b1;
        if (cnt_q == n_q - 3'd1) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      ST_DONE: begin
        if (owner_q == OWN_IF) begin
          if_done_o = 1'b1;
          if_data_o = data_q;
        end else begin
          mem_done_o   = 1'b1;
          mem_r_data_o = data_q;
        end
        state_d = ST_IDLE;
        cnt_d   = '0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a behavioural byte RAM.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_r_req;
  logic        mem_w_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_w_data;
  logic [1:0]  mem_size;
  logic        mem_done;
  logic [31:0] mem_r_data;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  int checks = 0;
  int errors = 0;

  logic [7:0] wmem [0:255];

  mem_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req_i     (if_req),
    .if_addr_i    (if_addr),
    .if_done_o    (if_done),
    .if_data_o    (if_data),
    .mem_r_req_i  (mem_r_req),
    .mem_w_req_i  (mem_w_req),
    .mem_addr_i   (mem_addr),
    .mem_w_data_i (mem_w_data),
    .mem_state_i  (mem_size),
    .mem_done_o   (mem_done),
    .mem_r_data_o (mem_r_data),
    .ram_din_i    (ram_din),
    .ram_dout_o   (ram_dout),
    .ram_a_o      (ram_a),
    .ram_wr_o     (ram_wr)
  );

  always #5 clk = ~clk;

  // Preloaded read contents of the RAM.
  function automatic logic [7:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 8'hA0;
      32'h0000_0001: return 8'hA1;
      32'h0000_0002: return 8'hA2;
      32'h0000_0003: return 8'hA3;
      32'h0000_0010: return 8'h80;
      32'h0000_0011: return 8'hFF;
      32'h0000_0100: return 8'h11;
      32'h0000_0101: return 8'h22;
      32'h0000_0102: return 8'h33;
      32'h0000_0103: return 8'h44;
      32'h0000_0200: return 8'h01;
      32'h0000_0201: return 8'h02;
      32'h0000_0202: return 8'h03;
      32'h0000_0203: return 8'h04;
      32'hFFFF_FFFE: return 8'h5A;
      32'hFFFF_FFFF: return 8'h6B;
      default:       return 8'h00;
    endcase
  endfunction

  // Synchronous RAM: read data follows the address by one cycle; writes recorded.
  always @(posedge clk) begin
    ram_din <= rom(ram_a);
    if (ram_wr) wmem[ram_a[7:0]] <= ram_dout;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 0; if_addr = '0; mem_r_req = 0; mem_w_req = 0;
    mem_addr = '0; mem_w_data = '0; mem_size = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ram_a !== 32'h0) begin errors++; $display("FAIL reset ram_a got %h exp %h", ram_a, 32'h0); end
    checks++; if (ram_wr !== 1'b0 || ram_dout !== 8'h00) begin errors++; $display("FAIL reset ram_wr/dout got %b/%h exp 0/00", ram_wr, ram_dout); end
    checks++; if (if_done !== 1'b0 || mem_done !== 1'b0) begin errors++; $display("FAIL reset done got %b/%b exp 0/0", if_done, mem_done); end
    checks++; if (if_data !== 32'h0 || mem_r_data !== 32'h0) begin errors++; $display("FAIL reset data got %h/%h exp 0/0", if_data, mem_r_data); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_word_load();
    logic [31:0] exp_a;
    @(negedge clk); mem_r_req = 1; mem_addr = 32'h100; mem_size = 2'b11;
    for (int c = 1; c <= 6; c++) begin
      step();
      exp_a = (c <= 4) ? 32'h100 + 32'(c - 1) : 32'h0;
      checks++; if (ram_a !== exp_a || ram_wr !== 1'b0) begin errors++; $display("FAIL word_load addr cyc %0d got %h/%b exp %h/0", c, ram_a, ram_wr, exp_a); end
      checks++; if (mem_done !== (c == 6)) begin errors++; $display("FAIL word_load done cyc %0d got %b exp %b", c, mem_done, (c == 6)); end
    end
    checks++; if (mem_r_data !== 32'h4433_2211) begin errors++; $display("FAIL word_load data got %h exp %h", mem_r_data, 32'h44332211); end
    mem_r_req = 0;
    step();
  endtask

  task automatic test_store();
    // SB 0x20 <- DEADBEEF
    @(negedge clk); mem_w_req = 1; mem_addr = 32'h20; mem_w_data = 32'hDEAD_BEEF; mem_size = 2'b00;
    step();
    checks++; if (ram_a !== 32'h20 || ram_wr !== 1'b1 || ram_dout !== 8'hEF) begin errors++; $display("FAIL sb write got %h/%b/%h exp 00000020/1/ef", ram_a, ram_wr, ram_dout); end
    checks++; if (mem_done !== 1'b0) begin errors++; $display("FAIL sb early_done got %b exp 0", mem_done); end
    step();
    checks++; if (mem_done !== 1'b1 || ram_wr !== 1'b0) begin errors++; $display("FAIL sb done got %b/%b exp 1/0", mem_done, ram_wr); end
    mem_w_req = 0;
    step();
    checks++; if (wmem[8'h20] !== 8'hEF) begin errors++; $display("FAIL sb ram got %h exp ef", wmem[8'h20]); end
    // SH 0x22 <- DEADBEEF
    @(negedge clk); mem_w_req = 1; mem_addr = 32'h22; mem_size = 2'b01;
    step();
    checks++; if (ram_a !== 32'h22 || ram_wr !== 1'b1 || ram_dout !== 8'hEF) begin errors++; $display("FAIL sh write0 got %h/%b/%h exp 00000022/1/ef", ram_a, ram_wr, ram_dout); end
    step();
    checks++; if (ram_a !== 32'h23 || ram_wr !== 1'b1 || ram_dout !== 8'hBE) begin errors++; $display("FAIL sh write1 got %h/%b/%h exp 00000023/1/be", ram_a, ram_wr, ram_dout); end
    checks++; if (mem_done !== 1'b0) begin errors++; $display("FAIL sh early_done got %b exp 0", mem_done); end
    step();
    checks++; if (mem_done !== 1'b1 || ram_wr !== 1'b0) begin errors++; $display("FAIL sh done got %b/%b exp 1/0", mem_done, ram_wr); end
    mem_w_req = 0;
    step();
    checks++; if (wmem[8'h22] !== 8'hEF || wmem[8'h23] !== 8'hBE) begin errors++; $display("FAIL sh ram got %h %h exp ef be", wmem[8'h22], wmem[8'h23]); end
  endtask

  task automatic test_arbitration();
    @(negedge clk);
    if_req = 1; if_addr = 32'h0;
    mem_r_req = 1; mem_addr = 32'h200; mem_size = 2'b11;
    for (int c = 1; c <= 13; c++) begin
      step();
      if (c == 2) begin
        checks++; if (ram_a !== 32'h201) begin errors++; $display("FAIL arb mem_addr got %h exp 00000201", ram_a); end
      end
      if (c == 9) begin
        checks++; if (ram_a !== 32'h1) begin errors++; $display("FAIL arb if_addr got %h exp 00000001", ram_a); end
      end
      checks++; if (mem_done !== (c == 6)) begin errors++; $display("FAIL arb mem_done cyc %0d got %b exp %b", c, mem_done, (c == 6)); end
      checks++; if (if_done !== (c == 13)) begin errors++; $display("FAIL arb if_done cyc %0d got %b exp %b", c, if_done, (c == 13)); end
      if (c == 6) begin
        checks++; if (mem_r_data !== 32'h0403_0201 || if_data !== 32'h0) begin errors++; $display("FAIL arb mem_data got %h if %h exp 04030201 if 0", mem_r_data, if_data); end
        mem_r_req = 0;
      end
      if (c == 13) begin
        checks++; if (if_data !== 32'hA3A2_A1A0) begin errors++; $display("FAIL arb if_data got %h exp a3a2a1a0", if_data); end
        if_req = 0;
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    @(negedge clk); mem_w_req = 1; mem_addr = 32'h30; mem_w_data = 32'h1234_5678; mem_size = 2'b11;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c <= 4) begin
        checks++; if (ram_a !== 32'h30 + 32'(c - 1) || ram_wr !== 1'b1) begin errors++; $display("FAIL b2b sw addr cyc %0d got %h/%b", c, ram_a, ram_wr); end
      end
      checks++; if (mem_done !== (c == 5)) begin errors++; $display("FAIL b2b sw done cyc %0d got %b exp %b", c, mem_done, (c == 5)); end
    end
    // New LHU held from the DONE cycle into the following IDLE cycle.
    mem_w_req = 0; mem_r_req = 1; mem_addr = 32'h10; mem_size = 2'b01;
    step();
    checks++; if (mem_done !== 1'b0 || ram_a !== 32'h0) begin errors++; $display("FAIL b2b idle got done %b addr %h exp 0/0", mem_done, ram_a); end
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 1) begin
        checks++; if (ram_a !== 32'h10) begin errors++; $display("FAIL b2b lhu addr got %h exp 00000010", ram_a); end
      end
      checks++; if (mem_done !== (c == 4)) begin errors++; $display("FAIL b2b lhu done cyc %0d got %b exp %b", c, mem_done, (c == 4)); end
    end
    checks++; if (mem_r_data !== 32'h0000_FF80) begin errors++; $display("FAIL b2b lhu data got %h exp 0000ff80", mem_r_data); end
    checks++; if ({wmem[8'h33], wmem[8'h32], wmem[8'h31], wmem[8'h30]} !== 32'h1234_5678) begin errors++; $display("FAIL b2b sw ram got %h%h%h%h exp 12345678", wmem[8'h33], wmem[8'h32], wmem[8'h31], wmem[8'h30]); end
    mem_r_req = 0;
    step();
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk); mem_r_req = 1; mem_addr = 32'h100; mem_size = 2'b11;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ram_a !== 32'h0 || ram_wr !== 1'b0 || ram_dout !== 8'h0) begin errors++; $display("FAIL rst_mid ram got %h/%b/%h exp 0/0/0", ram_a, ram_wr, ram_dout); end
    checks++; if (mem_done !== 1'b0 || if_done !== 1'b0 || mem_r_data !== 32'h0) begin errors++; $display("FAIL rst_mid outs got %b/%b/%h exp 0/0/0", mem_done, if_done, mem_r_data); end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (mem_done !== 1'b0 || ram_a !== 32'h0) begin errors++; $display("FAIL rst_mid hold cyc %0d got done %b addr %h", c, mem_done, ram_a); end
    end
    mem_r_req = 0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); mem_r_req = 1; mem_addr = 32'h101; mem_size = 2'b00;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 1) begin
        checks++; if (ram_a !== 32'h101) begin errors++; $display("FAIL rst_mid lbu addr got %h exp 00000101", ram_a); end
      end
      checks++; if (mem_done !== (c == 3)) begin errors++; $display("FAIL rst_mid lbu done cyc %0d got %b exp %b", c, mem_done, (c == 3)); end
    end
    checks++; if (mem_r_data !== 32'h0000_0022) begin errors++; $display("FAIL rst_mid lbu data got %h exp 00000022", mem_r_data); end
    mem_r_req = 0;
    step();
  endtask

  task automatic test_wrap_abort();
    logic [31:0] exp_a [0:3];
    exp_a[0] = 32'hFFFF_FFFE; exp_a[1] = 32'hFFFF_FFFF; exp_a[2] = 32'h0; exp_a[3] = 32'h1;
    @(negedge clk); if_req = 1; if_addr = 32'hFFFF_FFFE;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c <= 4) begin
        checks++; if (ram_a !== exp_a[c - 1]) begin errors++; $display("FAIL wrap addr cyc %0d got %h exp %h", c, ram_a, exp_a[c - 1]); end
      end
      if (c == 2) if_req = 0;
      checks++; if (if_done !== (c == 6)) begin errors++; $display("FAIL wrap done cyc %0d got %b exp %b", c, if_done, (c == 6)); end
    end
    checks++; if (if_data !== 32'hA1A0_6B5A) begin errors++; $display("FAIL wrap data got %h exp a1a06b5a", if_data); end
    step();
    checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL wrap no_refetch got %b exp 0", if_done); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_store();
    test_arbitration();
    test_back_to_back();
    test_reset_mid_op();
    test_wrap_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
